// File: rtl/jam_cost_server_if.sv
// Load/lookup/result bus of jam_cost_server.
// RESULT_CHECK_EN adds the ExpMinCost/ExpMatch/Pass signals used by the result checker.
interface jam_cost_server_if;
    logic        LdValid;
    logic [6:0]  LdData;
    logic        LdReady;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic        Valid;
    logic [9:0]  MinCost;
    logic [3:0]  MatchCount;
    logic        Loaded;
    logic        Done;
    logic [9:0]  ResMinCost;
    logic [3:0]  ResMatch;
    logic [15:0] LookupCount;
`ifdef RESULT_CHECK_EN
    logic [9:0]  ExpMinCost;
    logic [3:0]  ExpMatch;
    logic        Pass;
`endif

    modport slave (
        input  LdValid, LdData, W, J, Valid, MinCost, MatchCount,
`ifdef RESULT_CHECK_EN
        input  ExpMinCost, ExpMatch,
        output Pass,
`endif
        output LdReady, Cost, Loaded, Done, ResMinCost, ResMatch, LookupCount
    );

    modport master (
        output LdValid, LdData, W, J, Valid, MinCost, MatchCount,
`ifdef RESULT_CHECK_EN
        output ExpMinCost, ExpMatch,
        input  Pass,
`endif
        input  LdReady, Cost, Loaded, Done, ResMinCost, ResMatch, LookupCount
    );
endinterface

// File: rtl/jam_cost_server.sv
// 64x7 cost table server: row-major load, one-cycle lookup, solver result capture.
// Optional RESULT_CHECK_EN adds a Pass flag comparing the captured result with expected values.
module jam_cost_server (
    input  logic              CLK,
    input  logic              RST_N,
    jam_cost_server_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_addr;
    logic [6:0]  r_mem [0:63];
    logic [6:0]  r_cost;
    logic        r_ld_ready;
    logic        r_loaded;
    logic        r_done;
    logic [9:0]  r_res_min;
    logic [3:0]  r_res_match;
    logic [15:0] r_lookup_cnt;
`ifdef RESULT_CHECK_EN
    logic        r_pass;
`endif

    logic        w_wr_en;
    logic [5:0]  w_lk_addr;

    assign w_wr_en   = (r_state == ST_LOAD) && bus.LdValid;
    assign w_lk_addr = {bus.W, bus.J};

    // Table storage is deliberately unreset; a reload always rewrites all 64 entries.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[r_addr] <= bus.LdData;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_LOAD;
            r_addr       <= 6'd0;
            r_cost       <= 7'd0;
            r_ld_ready   <= 1'b1;
            r_loaded     <= 1'b0;
            r_done       <= 1'b0;
            r_res_min    <= 10'd0;
            r_res_match  <= 4'd0;
            r_lookup_cnt <= 16'd0;
`ifdef RESULT_CHECK_EN
            r_pass       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_cost <= 7'd0;
                    if (bus.LdValid) begin
                        // addr wraps from 63 to 0 on the final beat.
                        r_addr <= r_addr + 6'd1;
                        if (r_addr == 6'd63) begin
                            r_state    <= ST_SERVE;
                            r_loaded   <= 1'b1;
                            r_ld_ready <= 1'b0;
                        end
                    end
                end
                ST_SERVE: begin
                    r_cost <= r_mem[w_lk_addr];
                    if (r_lookup_cnt != 16'hFFFF) begin
                        r_lookup_cnt <= r_lookup_cnt + 16'd1;
                    end
                    if (bus.Valid) begin
                        r_res_min   <= bus.MinCost;
                        r_res_match <= bus.MatchCount;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
`ifdef RESULT_CHECK_EN
                        r_pass      <= (bus.MinCost == bus.ExpMinCost) &&
                                       (bus.MatchCount == bus.ExpMatch);
`endif
                    end
                end
                ST_DONE: begin
                    if (bus.LdValid) begin
                        // Restart beat only rearms loading; its data is dropped.
                        r_state      <= ST_LOAD;
                        r_addr       <= 6'd0;
                        r_cost       <= 7'd0;
                        r_ld_ready   <= 1'b1;
                        r_loaded     <= 1'b0;
                        r_done       <= 1'b0;
                        r_lookup_cnt <= 16'd0;
`ifdef RESULT_CHECK_EN
                        r_pass       <= 1'b0;
`endif
                    end else begin
                        r_cost <= r_mem[w_lk_addr];
                    end
                end
                default: begin
                    r_state    <= ST_LOAD;
                    r_addr     <= 6'd0;
                    r_cost     <= 7'd0;
                    r_ld_ready <= 1'b1;
                    r_loaded   <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Cost        = r_cost;
    assign bus.LdReady     = r_ld_ready;
    assign bus.Loaded      = r_loaded;
    assign bus.Done        = r_done;
    assign bus.ResMinCost  = r_res_min;
    assign bus.ResMatch    = r_res_match;
    assign bus.LookupCount = r_lookup_cnt;
`ifdef RESULT_CHECK_EN
    assign bus.Pass        = r_pass;
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// Scoreboard bench for jam_cost_server: stimulus queues cycle-tagged expectations, a negedge monitor checks them.
module tb_jam_cost_server;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    jam_cost_server_if bus ();

    jam_cost_server dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    localparam int F_COST   = 0;
    localparam int F_RDY    = 1;
    localparam int F_LOADED = 2;
    localparam int F_DONE   = 3;
    localparam int F_RESMIN = 4;
    localparam int F_RESMAT = 5;
    localparam int F_CNT    = 6;
    localparam int F_PASS   = 7;

    typedef struct {
        int    cyc;
        int    fld;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   sc     = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int field_val(int f);
        case (f)
            F_COST:   return int'(bus.Cost);
            F_RDY:    return int'(bus.LdReady);
            F_LOADED: return int'(bus.Loaded);
            F_DONE:   return int'(bus.Done);
            F_RESMIN: return int'(bus.ResMinCost);
            F_RESMAT: return int'(bus.ResMatch);
            F_CNT:    return int'(bus.LookupCount);
`ifdef RESULT_CHECK_EN
            F_PASS:   return int'(bus.Pass);
`endif
            default:  return -1;
        endcase
    endfunction

    // Monitor: compare every expectation whose cycle has come.
    always @(negedge CLK) begin
        exp_t e;
        int   a;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            a = field_val(e.fld);
            n_cmp++;
            if (a != e.val) begin
                n_bad++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.val, cyc);
            end
        end
    end

    task automatic expect_at(input int d, input int f, input int v, input string n);
        exp_t e;
        e.cyc  = cyc + d;
        e.fld  = f;
        e.val  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // mode 0: data = addr+1; mode 1: data = 127-addr. gap inserts idle/noise cycles.
    task automatic load_table(input int mode, input bit gap);
        for (int a = 0; a < 64; a++) begin
            bus.LdValid = 1'b1;
            bus.LdData  = (mode == 0) ? 7'(a + 1) : 7'(127 - a);
            if (a == 20) expect_at(1, F_COST, 0, "cost_zero_in_load");
            if (a == 62) begin
                expect_at(1, F_LOADED, 0, "loaded_before_last_beat");
                expect_at(1, F_RDY, 1, "ldready_in_load");
            end
            if (a == 63) begin
                expect_at(1, F_LOADED, 1, "loaded_after_64_beats");
                expect_at(1, F_RDY, 0, "ldready_low_in_serve");
                expect_at(1, F_COST, 0, "cost_zero_on_load_exit");
            end
            step();
            if (gap && (a % 2 == 0)) begin
                bus.LdValid = 1'b0;
                bus.LdData  = 7'h7F;
                bus.Valid   = 1'b1;
                bus.W       = 3'd7;
                bus.J       = 3'd7;
                step();
                bus.Valid   = 1'b0;
            end
        end
        bus.LdValid = 1'b0;
        sc = 0;
    endtask

    task automatic lookup(input int w, input int j, input int c);
        bus.W = 3'(w);
        bus.J = 3'(j);
        expect_at(1, F_COST, c, "cost_lookup");
        step();
        sc++;
    endtask

    task automatic capture(input int mc, input int mt, input int w, input int j, input int c, input int pass);
        bus.Valid      = 1'b1;
        bus.MinCost    = 10'(mc);
        bus.MatchCount = 4'(mt);
        bus.W          = 3'(w);
        bus.J          = 3'(j);
        expect_at(1, F_COST, c, "cost_on_capture");
        expect_at(1, F_DONE, 1, "done_set");
        expect_at(1, F_RESMIN, mc, "res_min_cost");
        expect_at(1, F_RESMAT, mt, "res_match");
        expect_at(1, F_CNT, sc + 1, "lookup_count_capture");
        expect_at(1, F_RDY, 0, "ldready_low_in_done");
`ifdef RESULT_CHECK_EN
        expect_at(1, F_PASS, pass, "pass_flag");
`endif
        step();
        sc++;
        bus.Valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.LdValid    = 1'b0;
        bus.LdData     = 7'd0;
        bus.W          = 3'd0;
        bus.J          = 3'd0;
        bus.Valid      = 1'b0;
        bus.MinCost    = 10'd0;
        bus.MatchCount = 4'd0;
`ifdef RESULT_CHECK_EN
        bus.ExpMinCost = 10'd417;
        bus.ExpMatch   = 4'd3;
`endif
        step();
        expect_at(0, F_COST, 0, "rst_cost");
        expect_at(0, F_RDY, 1, "rst_ldready");
        expect_at(0, F_LOADED, 0, "rst_loaded");
        expect_at(0, F_DONE, 0, "rst_done");
        expect_at(0, F_RESMIN, 0, "rst_res_min");
        expect_at(0, F_RESMAT, 0, "rst_res_match");
        expect_at(0, F_CNT, 0, "rst_lookup_count");
`ifdef RESULT_CHECK_EN
        expect_at(0, F_PASS, 0, "rst_pass");
`endif
        step();
        RST_N = 1'b1;
        expect_at(1, F_RDY, 1, "ldready_after_reset");
        step();

        // 40 junk beats, then an asynchronous reset mid-load.
        for (int a = 0; a < 40; a++) begin
            bus.LdValid = 1'b1;
            bus.LdData  = 7'h55;
            step();
        end
        bus.LdValid = 1'b0;
        RST_N = 1'b0;
        expect_at(0, F_LOADED, 0, "midload_rst_loaded");
        expect_at(0, F_RDY, 1, "midload_rst_ldready");
        expect_at(0, F_COST, 0, "midload_rst_cost");
        step();
        RST_N = 1'b1;
        step();

        load_table(0, 1'b1);

        lookup(3, 5, 30);
        lookup(7, 7, 64);
        bus.LdValid = 1'b1;
        bus.LdData  = 7'h11;
        expect_at(1, F_RDY, 0, "ldvalid_ignored_in_serve");
        lookup(0, 0, 1);
        bus.LdValid = 1'b0;
        lookup(5, 2, 43);
        while (sc < 50) lookup(1, 1, 10);
        expect_at(0, F_CNT, 50, "lookup_count_50");
        while (sc < 100) lookup(2, 0, 17);
        expect_at(0, F_DONE, 0, "done_low_in_serve");
        capture(417, 3, 2, 6, 23, 1);

        // DONE: Valid ignored, count holds, lookups still served.
        bus.Valid      = 1'b1;
        bus.MinCost    = 10'd999;
        bus.MatchCount = 4'd9;
        bus.W          = 3'd6;
        bus.J          = 3'd1;
        expect_at(1, F_COST, 50, "cost_in_done");
        expect_at(1, F_RESMIN, 417, "res_min_holds");
        expect_at(1, F_RESMAT, 3, "res_match_holds");
        expect_at(1, F_CNT, 101, "lookup_count_holds");
        step();
        bus.Valid = 1'b0;
        step();

        // Restart: this beat must not be written.
        bus.LdValid = 1'b1;
        bus.LdData  = 7'd99;
        expect_at(0, F_DONE, 1, "done_before_restart");
        expect_at(1, F_LOADED, 0, "restart_loaded");
        expect_at(1, F_DONE, 0, "restart_done");
        expect_at(1, F_CNT, 0, "restart_lookup_count");
        expect_at(1, F_RDY, 1, "restart_ldready");
        expect_at(1, F_COST, 0, "restart_cost");
`ifdef RESULT_CHECK_EN
        expect_at(1, F_PASS, 0, "restart_pass_clear");
`endif
        step();

        load_table(1, 1'b0);
        lookup(0, 0, 127);
        lookup(3, 5, 98);
        lookup(7, 7, 64);
        lookup(4, 1, 94);
        capture(418, 3, 0, 7, 120, 0);

        step();
        step();
        step();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
